// File: rtl/ctr_buffer.sv
// Circular control-transfer record buffer fed by commit ports,
// with a registered, youngest-first indexed read port.
package ctr_buffer_pkg;
   typedef struct packed {
      int unsigned XLEN;
      int unsigned NrCommitPorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      XLEN: 32,
      NrCommitPorts: 2
   };
endpackage

module ctr_buffer
   import ctr_buffer_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
   parameter int unsigned NrPorts = CVA6Cfg.NrCommitPorts,
   parameter int unsigned Depth   = 16,
   parameter int unsigned TypeW   = 4,
   localparam int unsigned XLEN   = CVA6Cfg.XLEN,
   localparam int unsigned IdxW   = $clog2(Depth)
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NrPorts-1:0]       ctr_valid_i,
   input  logic [NrPorts*XLEN-1:0]  ctr_source_i,
   input  logic [NrPorts*XLEN-1:0]  ctr_target_i,
   input  logic [NrPorts*TypeW-1:0] ctr_type_i,
   input  logic [2**TypeW-1:0]      type_inhibit_i,
   input  logic                     freeze_i,
   input  logic                     clear_i,
   input  logic                     rd_req_i,
   input  logic [IdxW-1:0]          rd_idx_i,
   output logic                     rd_valid_o,
   output logic                     rd_hit_o,
   output logic [XLEN-1:0]          rd_source_o,
   output logic [XLEN-1:0]          rd_target_o,
   output logic [TypeW-1:0]         rd_type_o,
   output logic [IdxW:0]            count_o,
   output logic                     wrap_o
);

   logic [XLEN-1:0]  r_src  [Depth];
   logic [XLEN-1:0]  r_tgt  [Depth];
   logic [TypeW-1:0] r_type [Depth];

   logic [IdxW-1:0]  r_wptr;
   logic [IdxW:0]    r_count;
   logic             r_wrap;

   logic             r_rd_valid;
   logic             r_rd_hit;
   logic [XLEN-1:0]  r_rd_src;
   logic [XLEN-1:0]  r_rd_tgt;
   logic [TypeW-1:0] r_rd_type;

   logic [NrPorts-1:0] w_acc;
   logic [IdxW-1:0]    w_wr_idx [NrPorts];
   logic [IdxW:0]      w_n;
   logic [IdxW+1:0]    w_sum;
   logic               w_over;
   logic [IdxW-1:0]    w_rd_phys;
   logic               w_rd_hit;

   // Accepted ports are packed densely from wptr in port order.
   always_comb begin
      logic [IdxW:0] v_n;
      logic [TypeW-1:0] v_ty;
      v_n = '0;
      v_ty = '0;
      w_acc = '0;
      for (int p = 0; p < NrPorts; p++) begin
         v_ty = ctr_type_i[p*TypeW +: TypeW];
         w_acc[p] = ctr_valid_i[p]
                  & ~type_inhibit_i[v_ty]
                  & ~freeze_i
                  & ~clear_i;
         w_wr_idx[p] = r_wptr + v_n[IdxW-1:0];
         v_n = v_n + {{IdxW{1'b0}}, w_acc[p]};
      end
      w_n = v_n;
   end

   assign w_sum     = {1'b0, r_count} + {1'b0, w_n};
   assign w_over    = w_sum > (IdxW+2)'(Depth);
   assign w_rd_phys = r_wptr - IdxW'(1) - rd_idx_i;
   assign w_rd_hit  = {1'b0, rd_idx_i} < r_count;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr  <= '0;
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wptr <= r_wptr + w_n[IdxW-1:0];
         if (w_over) begin
            r_count <= (IdxW+1)'(Depth);
            r_wrap  <= 1'b1;
         end else begin
            r_count <= w_sum[IdxW:0];
         end
      end
   end

   // Storage needs no reset: count gates visibility.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NrPorts; p++) begin
         if (w_acc[p]) begin
            r_src[w_wr_idx[p]]  <= ctr_source_i[p*XLEN +: XLEN];
            r_tgt[w_wr_idx[p]]  <= ctr_target_i[p*XLEN +: XLEN];
            r_type[w_wr_idx[p]] <= ctr_type_i[p*TypeW +: TypeW];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
         r_rd_src   <= '0;
         r_rd_tgt   <= '0;
         r_rd_type  <= '0;
      end else begin
         r_rd_valid <= rd_req_i;
         if (rd_req_i) begin
            r_rd_hit <= w_rd_hit;
            if (w_rd_hit) begin
               r_rd_src  <= r_src[w_rd_phys];
               r_rd_tgt  <= r_tgt[w_rd_phys];
               r_rd_type <= r_type[w_rd_phys];
            end else begin
               r_rd_src  <= '0;
               r_rd_tgt  <= '0;
               r_rd_type <= '0;
            end
         end
      end
   end

   assign rd_valid_o  = r_rd_valid;
   assign rd_hit_o    = r_rd_hit;
   assign rd_source_o = r_rd_src;
   assign rd_target_o = r_rd_tgt;
   assign rd_type_o   = r_rd_type;
   assign count_o     = r_count;
   assign wrap_o      = r_wrap;

endmodule

// File: tb/tb_ctr_buffer.sv
// Scoreboard bench for ctr_buffer: directed commits and reads,
// responses checked by a monitor against queued expectations.
module tb_ctr_buffer;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [1:0]  valid = '0;
   logic [63:0] src = '0;
   logic [63:0] tgt = '0;
   logic [7:0]  ty = '0;
   logic [15:0] inhibit = '0;
   logic        freeze = 1'b0;
   logic        clear = 1'b0;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic        rd_valid;
   logic        rd_hit;
   logic [31:0] rd_src;
   logic [31:0] rd_tgt;
   logic [3:0]  rd_type;
   logic [4:0]  count;
   logic        wrap;

   ctr_buffer dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .ctr_valid_i    (valid),
      .ctr_source_i   (src),
      .ctr_target_i   (tgt),
      .ctr_type_i     (ty),
      .type_inhibit_i (inhibit),
      .freeze_i       (freeze),
      .clear_i        (clear),
      .rd_req_i       (rd_req),
      .rd_idx_i       (rd_idx),
      .rd_valid_o     (rd_valid),
      .rd_hit_o       (rd_hit),
      .rd_source_o    (rd_src),
      .rd_target_o    (rd_tgt),
      .rd_type_o      (rd_type),
      .count_o        (count),
      .wrap_o         (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic [31:0] src;
      logic [31:0] tgt;
      logic [3:0]  ty;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
      end
   endtask

   // Monitor: every read response pops one expectation.
   always @(negedge clk) begin
      if (rstn && rd_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_extra: got rd_valid_o=1, expected 0");
         end else begin
            m_e = q.pop_front();
            chk("rd_hit", 64'(rd_hit), 64'(m_e.hit));
            chk("rd_source", 64'(rd_src), 64'(m_e.src));
            chk("rd_target", 64'(rd_tgt), 64'(m_e.tgt));
            chk("rd_type", 64'(rd_type), 64'(m_e.ty));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Targets are always source + 0x1000.
   task automatic drive(input logic [1:0] v,
                        input logic [31:0] s0,
                        input logic [3:0] t0,
                        input logic [31:0] s1,
                        input logic [3:0] t1);
      valid = v;
      src = {s1, s0};
      tgt = {s1 + 32'h1000, s0 + 32'h1000};
      ty = {t1, t0};
   endtask

   task automatic commit(input logic [1:0] v,
                         input logic [31:0] s0,
                         input logic [3:0] t0,
                         input logic [31:0] s1,
                         input logic [3:0] t1);
      drive(v, s0, t0, s1, t1);
      step();
      valid = '0;
   endtask

   task automatic expect_rd(input int idx,
                            input logic hit,
                            input logic [31:0] s,
                            input logic [3:0] t);
      exp_t e;
      e.hit = hit;
      e.src = hit ? s : 32'h0;
      e.tgt = hit ? s + 32'h1000 : 32'h0;
      e.ty = hit ? t : 4'h0;
      q.push_back(e);
      rd_req = 1'b1;
      rd_idx = 4'(idx);
   endtask

   task automatic rd(input int idx,
                     input logic hit,
                     input logic [31:0] s,
                     input logic [3:0] t);
      expect_rd(idx, hit, s, t);
      step();
      rd_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rstn = 1'b0;
      #2;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_wrap", 64'(wrap), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_hit", 64'(rd_hit), 64'd0);
      chk("rst_rd_source", 64'(rd_src), 64'd0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      step();

      commit(2'b01, 32'h100, 4'd1, 32'h0, 4'd0);
      commit(2'b01, 32'h200, 4'd1, 32'h0, 4'd0);
      commit(2'b01, 32'h300, 4'd1, 32'h0, 4'd0);
      chk("single_count", 64'(count), 64'd3);
      rd(0, 1'b1, 32'h300, 4'd1);
      rd(2, 1'b1, 32'h100, 4'd1);
      rd(3, 1'b0, 32'h0, 4'd0);

      commit(2'b11, 32'hA0, 4'd2, 32'hB0, 4'd2);
      chk("dual_count", 64'(count), 64'd5);
      rd(0, 1'b1, 32'hB0, 4'd2);
      rd(1, 1'b1, 32'hA0, 4'd2);

      inhibit = 16'h0008;
      commit(2'b11, 32'hC0, 4'd3, 32'hD0, 4'd1);
      chk("inhibit_count_a", 64'(count), 64'd6);
      rd(0, 1'b1, 32'hD0, 4'd1);
      rd(1, 1'b1, 32'hB0, 4'd2);
      commit(2'b11, 32'hE0, 4'd1, 32'hE8, 4'd3);
      chk("inhibit_count_b", 64'(count), 64'd7);
      rd(0, 1'b1, 32'hE0, 4'd1);
      rd(1, 1'b1, 32'hD0, 4'd1);
      inhibit = '0;

      freeze = 1'b1;
      commit(2'b11, 32'h11, 4'd1, 32'h22, 4'd1);
      commit(2'b11, 32'h33, 4'd1, 32'h44, 4'd1);
      chk("freeze_count", 64'(count), 64'd7);
      chk("freeze_wrap", 64'(wrap), 64'd0);
      rd(0, 1'b1, 32'hE0, 4'd1);
      freeze = 1'b0;

      expect_rd(0, 1'b1, 32'hE0, 4'd1);
      commit(2'b01, 32'hF0, 4'd6, 32'h0, 4'd0);
      rd_req = 1'b0;
      chk("rdw_count", 64'(count), 64'd8);
      rd(0, 1'b1, 32'hF0, 4'd6);

      clear = 1'b1;
      commit(2'b01, 32'h777, 4'd1, 32'h0, 4'd0);
      clear = 1'b0;
      chk("clear_count", 64'(count), 64'd0);
      chk("clear_wrap", 64'(wrap), 64'd0);
      rd(0, 1'b0, 32'h0, 4'd0);

      for (int i = 0; i < 18; i++) begin
         commit(2'b01, 32'(i), 4'd5, 32'h0, 4'd0);
      end
      chk("wrap_count", 64'(count), 64'd16);
      chk("wrap_flag", 64'(wrap), 64'd1);
      rd(0, 1'b1, 32'd17, 4'd5);
      rd(1, 1'b1, 32'd16, 4'd5);
      rd(15, 1'b1, 32'd2, 4'd5);
      commit(2'b11, 32'h60, 4'd4, 32'h61, 4'd4);
      chk("wrap_sat", 64'(count), 64'd16);
      rd(0, 1'b1, 32'h61, 4'd4);
      rd(15, 1'b1, 32'd4, 4'd5);
      step();

      #2 rstn = 1'b0;
      #2;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_wrap", 64'(wrap), 64'd0);
      chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("mid_rst_rd_hit", 64'(rd_hit), 64'd0);
      chk("mid_rst_rd_source", 64'(rd_src), 64'd0);
      chk("mid_rst_rd_target", 64'(rd_tgt), 64'd0);
      chk("mid_rst_rd_type", 64'(rd_type), 64'd0);
      step();
      rstn = 1'b1;
      step();

      commit(2'b01, 32'h555, 4'd7, 32'h0, 4'd0);
      chk("post_rst_count", 64'(count), 64'd1);
      rd(0, 1'b1, 32'h555, 4'd7);
      rd(1, 1'b0, 32'h0, 4'd0);

      repeat (3) step();
      chk("sb_drain", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
